pong_paddle_ctrl: RTL and testbench
===================================

# pong_paddle_ctrl

Per-paddle motion controller for the Pong datapath. It arbitrates ownership of one paddle between the human button pair and the AI tracker's move command, and advances the paddle position once per frame tick with optional acceleration. It clamps the position to the playfield and drives `paddle_pos` to the renderer, the collision logic and the AI tracker.

## Interface
- `SCREEN_H`, 480: playfield height in pixels.
- `PADDLE_H`, 80: paddle height in pixels; driven constant on `paddle_height`.
- `MAX_SPEED`, 8: maximum step per frame in pixels.
- `AI_TIMEOUT`, 120: number of consecutive idle human frames before AI takeover.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `frame_tick` input 1: single-cycle pulse, once per video frame.
- `enable` input 1: game in play; low freezes motion.
- `btn_in` input 2: human command (2'b10 up, 2'b01 down, 2'b00/2'b11 none).
- `ai_in` input 2: AI command, same encoding.
- `ai_allow` input 1: permits AI takeover.
- `paddle_pos` output 10: top edge of the paddle, in pixels.
- `paddle_height` output 10: equals `PADDLE_H`.
- `owner` output 1: 0 human, 1 AI.
- `moving` output 1: high while `speed` is nonzero.

## Operation
- All state updates occur only on clock edges where `frame_tick` = 1. Between ticks every register holds.
- **Reset values**
  - `paddle_pos` = (SCREEN_H-PADDLE_H)/2, which is 200 at defaults.
  - `speed` = 0, `dir` = none, `owner` = 0, `idle_cnt` = 0, `moving` = 0.
- **Ownership FSM**, states HUMAN and AI:
  - HUMAN: a valid `btn_in` clears `idle_cnt`. Otherwise `idle_cnt` increments and saturates at `AI_TIMEOUT`.
  - HUMAN → AI when `idle_cnt` reaches `AI_TIMEOUT` and `ai_allow` = 1. Both the increment to `AI_TIMEOUT` and the transition take effect on the same tick. If `ai_allow` = 0, the FSM stays in HUMAN with `idle_cnt` saturated.
  - AI → HUMAN on any tick with a valid `btn_in`. That tick's `btn_in` is used as the command, so the human has priority. `idle_cnt` is cleared.
  - AI → HUMAN when `ai_allow` falls. This happens on the next tick, and `idle_cnt` is cleared.
- **Command selection**: `cmd` = `btn_in` in HUMAN, `ai_in` in AI. Codes 00 and 11 mean none.
- **Speed**:
  - `cmd` none → `speed` = 0.
  - `cmd` ≠ `dir` → `speed` = 1.
  - `cmd` = `dir` → `speed` = min(`speed`+1, MAX_SPEED).
  - `dir` takes the value of `cmd`.
- **Position**:
  - The new `speed` is added (down) or subtracted (up) in 11-bit signed arithmetic.
  - The result is clamped to [0, SCREEN_H-PADDLE_H].
  - Hitting a clamp sets `speed` to 0 and `dir` to none.
- **Enable low**:
  - `speed` = 0, `dir` = none, position is held.
  - The ownership FSM and `idle_cnt` freeze.
- **Reset mid-motion**: all registers return to their reset values immediately (asynchronous).

## Timing
- New `paddle_pos`, `owner` and `moving` are visible the cycle after the `frame_tick` edge, giving 1-cycle latency.
- `paddle_pos` changes at most once per frame. No handshake is used; consumers sample at any time.
- `frame_tick` held high for N cycles counts as N ticks. This is the upstream's responsibility.

## Configuration
- `PONG_PADDLE_ACCEL_EN` defined: acceleration behaves as described in Operation.
- `PONG_PADDLE_ACCEL_EN` undefined: any valid `cmd` sets `speed` = MAX_SPEED immediately, so motion is a constant step. Clamp rules are unchanged.

## Structure
- Shared package `pong_pkg` holds:
  - move codes `MOVE_UP` = 2'b10, `MOVE_DOWN` = 2'b01, `MOVE_NONE` = 2'b00;
  - the owner encoding `OWNER_HUMAN`/`OWNER_AI`;
  - the screen-size constants.
- Sub-module `paddle_owner_arb` contains the ownership FSM, `idle_cnt` and the command mux. The top level contains speed, position and clamping.

## Test plan
- **Reset**: assert `reset` mid-motion → `paddle_pos` = 200, `speed` = 0, `owner` = 0 on the next cycle.
- **Acceleration** (ACCEL_EN): `btn_in` = 01 for 3 ticks from 200 → `paddle_pos` 201, 203, 206. Then `btn_in` = 10 → 205, since `speed` resets to 1.
- **Clamp**: `paddle_pos` = 396, `speed` = 8, down → 400 with `moving` = 0. From 3, up with `speed` 5 → 0.
- **Takeover**: `ai_allow` = 1 with no buttons → `owner` = 1 after tick 120. `ai_in` = 10 then moves the paddle up.
- **Human override**: in AI state, `btn_in` = 01 on one tick → `owner` = 0 on that tick, and the paddle moves down by 1 rather than following `ai_in`.
- **Enable low**: held 5 ticks with `btn_in` = 01 → `paddle_pos` unchanged and `idle_cnt` frozen.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong constants: move codes, owner encoding and default playfield geometry.
package pong_pkg;

  localparam int DEF_SCREEN_H   = 480;
  localparam int DEF_PADDLE_H   = 80;
  localparam int DEF_MAX_SPEED  = 8;
  localparam int DEF_AI_TIMEOUT = 120;

  localparam logic [1:0] MOVE_UP   = 2'b10;
  localparam logic [1:0] MOVE_DOWN = 2'b01;
  localparam logic [1:0] MOVE_NONE = 2'b00;

  typedef enum logic {
    OWNER_HUMAN = 1'b0,
    OWNER_AI    = 1'b1
  } owner_e;

  // 00 and 11 both mean "no move".
  function automatic logic is_move(input logic [1:0] c);
    return (c == MOVE_UP) || (c == MOVE_DOWN);
  endfunction

endpackage

// File: rtl/paddle_owner_arb.sv
// Paddle ownership FSM: idle timeout hands control to the AI, any button takes it back.
module paddle_owner_arb
  import pong_pkg::*;
#(
  parameter int AI_TIMEOUT = DEF_AI_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [1:0] btn_in,
  input  logic [1:0] ai_in,
  input  logic       ai_allow,
  output logic [1:0] cmd,
  output logic       owner
);

  localparam int CW = $clog2(AI_TIMEOUT + 1);
  localparam logic [CW-1:0] IDLE_MAX = CW'(AI_TIMEOUT);

  typedef enum logic {ST_HUMAN, ST_AI} state_e;

  state_e        state, state_nxt;
  logic [CW-1:0] idle_cnt, idle_nxt;
  logic          btn_valid;

  assign btn_valid = is_move(btn_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_HUMAN;
      idle_cnt <= '0;
    end else if (frame_tick && enable) begin
      state    <= state_nxt;
      idle_cnt <= idle_nxt;
    end
  end

  // The command follows whoever owns the paddle after this tick, so a
  // button press during AI control is obeyed on the very same tick.
  always_comb begin
    state_nxt = state;
    idle_nxt  = idle_cnt;
    cmd       = btn_in;
    case (state)
      ST_HUMAN: begin
        if (btn_valid) begin
          idle_nxt = '0;
        end else begin
          if (idle_cnt != IDLE_MAX) idle_nxt = idle_cnt + CW'(1);
          if (idle_nxt == IDLE_MAX && ai_allow) state_nxt = ST_AI;
        end
      end
      ST_AI: begin
        if (btn_valid || !ai_allow) begin
          state_nxt = ST_HUMAN;
          idle_nxt  = '0;
        end else begin
          cmd = ai_in;
        end
      end
      default: state_nxt = ST_HUMAN;
    endcase
  end

  assign owner = (state == ST_AI) ? OWNER_AI : OWNER_HUMAN;

endmodule

// File: rtl/pong_paddle_ctrl.sv
// Per-paddle motion controller: speed, position and playfield clamping, one update per frame.
// Define PONG_PADDLE_ACCEL_EN for ramped speed; otherwise every move steps MAX_SPEED.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H   = DEF_SCREEN_H,
  parameter int PADDLE_H   = DEF_PADDLE_H,
  parameter int MAX_SPEED  = DEF_MAX_SPEED,
  parameter int AI_TIMEOUT = DEF_AI_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [1:0] btn_in,
  input  logic [1:0] ai_in,
  input  logic       ai_allow,
  output logic [9:0] paddle_pos,
  output logic [9:0] paddle_height,
  output logic       owner,
  output logic       moving
);

  localparam int SW = $clog2(MAX_SPEED + 1);
  localparam logic [9:0]         POS_RST   = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0]         POS_MAX   = 10'(SCREEN_H - PADDLE_H);
  localparam logic signed [10:0] POS_MAX_S = 11'(SCREEN_H - PADDLE_H);
  localparam logic [SW-1:0]      SPD_MAX   = SW'(MAX_SPEED);

  logic [1:0]         cmd, cmd_n;
  logic [9:0]         pos, pos_nxt;
  logic [SW-1:0]      speed, speed_nxt;
  logic signed [10:0] pos_ext, spd_ext, sum;

  paddle_owner_arb #(.AI_TIMEOUT(AI_TIMEOUT)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .enable     (enable),
    .btn_in     (btn_in),
    .ai_in      (ai_in),
    .ai_allow   (ai_allow),
    .cmd        (cmd),
    .owner      (owner)
  );

`ifdef PONG_PADDLE_ACCEL_EN
  logic [1:0] dir, dir_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)           dir <= MOVE_NONE;
    else if (frame_tick) dir <= dir_nxt;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos   <= POS_RST;
      speed <= '0;
    end else if (frame_tick) begin
      pos   <= pos_nxt;
      speed <= speed_nxt;
    end
  end

  always_comb begin
    cmd_n     = is_move(cmd) ? cmd : MOVE_NONE;
    speed_nxt = '0;
    pos_nxt   = pos;
    pos_ext   = {1'b0, pos};
    spd_ext   = '0;
    sum       = pos_ext;
`ifdef PONG_PADDLE_ACCEL_EN
    dir_nxt   = MOVE_NONE;
`endif
    if (enable && cmd_n != MOVE_NONE) begin
`ifdef PONG_PADDLE_ACCEL_EN
      if (cmd_n != dir)          speed_nxt = SW'(1);
      else if (speed >= SPD_MAX) speed_nxt = SPD_MAX;
      else                       speed_nxt = speed + SW'(1);
      dir_nxt = cmd_n;
`else
      speed_nxt = SPD_MAX;
`endif
      spd_ext = 11'(speed_nxt);
      sum     = (cmd_n == MOVE_DOWN) ? pos_ext + spd_ext : pos_ext - spd_ext;
      // Running into either wall stops the paddle dead.
      if (sum < 0 || sum > POS_MAX_S) begin
        pos_nxt   = (sum < 0) ? 10'd0 : POS_MAX;
        speed_nxt = '0;
`ifdef PONG_PADDLE_ACCEL_EN
        dir_nxt   = MOVE_NONE;
`endif
      end else begin
        pos_nxt = sum[9:0];
      end
    end
  end

  assign paddle_pos    = pos;
  assign paddle_height = 10'(PADDLE_H);
  assign moving        = (speed != '0);

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Directed bench for pong_paddle_ctrl with a behavioural scoreboard of per-tick outputs.
module tb_pong_paddle_ctrl;
  import pong_pkg::*;

  logic       clk = 1'b0;
  logic       reset, frame_tick, enable, ai_allow;
  logic [1:0] btn_in, ai_in;
  logic [9:0] paddle_pos, paddle_height;
  logic       owner, moving;

  always #5 clk = ~clk;

  pong_paddle_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .enable        (enable),
    .btn_in        (btn_in),
    .ai_in         (ai_in),
    .ai_allow      (ai_allow),
    .paddle_pos    (paddle_pos),
    .paddle_height (paddle_height),
    .owner         (owner),
    .moving        (moving)
  );

  typedef struct {
    int pos;
    bit own;
    bit mov;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  int         m_pos, m_speed, m_idle;
  bit         m_owner;
  logic [1:0] m_dir;

`ifdef PONG_PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos = 200; m_speed = 0; m_idle = 0; m_owner = 0; m_dir = 2'b00;
    sb.delete();
  endtask

  task automatic model(input logic [1:0] b, input logic [1:0] a, input bit allow, input bit en);
    logic [1:0] c;
    bit         bv;
    int         np;
    if (!en) begin
      m_speed = 0;
      m_dir   = 2'b00;
    end else begin
      bv = (b == 2'b10) || (b == 2'b01);
      if (!m_owner) begin
        c = b;
        if (bv) m_idle = 0;
        else begin
          if (m_idle < 120) m_idle++;
          if (m_idle == 120 && allow) m_owner = 1;
        end
      end else if (bv || !allow) begin
        c = b; m_owner = 0; m_idle = 0;
      end else begin
        c = a;
      end
      if (c == 2'b11) c = 2'b00;
      if (c == 2'b00)                m_speed = 0;
      else if (!ACCEL)               m_speed = 8;
      else if (c != m_dir)           m_speed = 1;
      else                           m_speed = (m_speed >= 8) ? 8 : m_speed + 1;
      m_dir = c;
      np = m_pos;
      if (c == 2'b01) np = m_pos + m_speed;
      if (c == 2'b10) np = m_pos - m_speed;
      if (np < 0 || np > 400) begin
        np = (np < 0) ? 0 : 400;
        m_speed = 0;
        m_dir   = 2'b00;
      end
      m_pos = np;
    end
  endtask

  // One frame tick followed by one quiet cycle; outputs must hold across the gap.
  task automatic step(input string tag, input logic [1:0] b, input logic [1:0] a,
                      input bit allow, input bit en);
    exp_t e;
    btn_in = b; ai_in = a; ai_allow = allow; enable = en; frame_tick = 1'b1;
    model(b, a, allow, en);
    e.pos = m_pos; e.own = m_owner; e.mov = (m_speed != 0);
    sb.push_back(e);
    @(posedge clk); #1;
    frame_tick = 1'b0;
    e = sb.pop_front();
    chk({tag, ".pos"},    32'(paddle_pos), 32'(e.pos));
    chk({tag, ".owner"},  32'(owner),      32'(e.own));
    chk({tag, ".moving"}, 32'(moving),     32'(e.mov));
    @(posedge clk); #1;
    chk({tag, ".hold"},   32'(paddle_pos), 32'(e.pos));
  endtask

  initial begin
    int p0;
    reset = 1'b1; frame_tick = 1'b0; enable = 1'b1;
    btn_in = 2'b00; ai_in = 2'b00; ai_allow = 1'b0;
    model_reset();
    #12;
    chk("rst.pos",    32'(paddle_pos),    32'd200);
    chk("rst.owner",  32'(owner),         32'd0);
    chk("rst.moving", 32'(moving),        32'd0);
    chk("rst.height", 32'(paddle_height), 32'd80);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 3; i++) step("accel_dn", 2'b01, 2'b00, 1'b0, 1'b1);
    chk("accel_dn3", 32'(paddle_pos), ACCEL ? 32'd206 : 32'd224);
    step("reverse", 2'b10, 2'b00, 1'b0, 1'b1);
    chk("reverse_pos", 32'(paddle_pos), ACCEL ? 32'd205 : 32'd216);

    for (int i = 0; i < 40; i++) step("clamp_dn", 2'b01, 2'b00, 1'b0, 1'b1);
    chk("clamp_dn_pos", 32'(paddle_pos), 32'd400);
    chk("clamp_dn_mov", 32'(moving),     32'd0);

    for (int i = 0; i < 80; i++) step("clamp_up", 2'b10, 2'b00, 1'b0, 1'b1);
    chk("clamp_up_pos", 32'(paddle_pos), 32'd0);
    chk("clamp_up_mov", 32'(moving),     32'd0);

    for (int i = 0; i < 20; i++) step("mid", 2'b01, 2'b00, 1'b0, 1'b1);

    // Idle run interrupted by a frozen stretch: the timeout must not restart.
    for (int i = 0; i < 60; i++) step("idle_a", 2'b00, 2'b00, 1'b1, 1'b1);
    p0 = int'(paddle_pos);
    for (int i = 0; i < 5; i++) step("en_low", 2'b01, 2'b00, 1'b1, 1'b0);
    chk("en_low_pos", 32'(paddle_pos), 32'(p0));
    for (int i = 0; i < 59; i++) step("idle_b", 2'b00, 2'b00, 1'b1, 1'b1);
    chk("pre_takeover", 32'(owner), 32'd0);
    step("takeover", 2'b00, 2'b00, 1'b1, 1'b1);
    chk("takeover_owner", 32'(owner), 32'd1);

    p0 = int'(paddle_pos);
    for (int i = 0; i < 5; i++) step("ai_up", 2'b00, 2'b10, 1'b1, 1'b1);
    chk("ai_up_moved", 32'(int'(paddle_pos) < p0), 32'd1);

    p0 = int'(paddle_pos);
    step("override", 2'b01, 2'b10, 1'b1, 1'b1);
    chk("override_owner", 32'(owner),      32'd0);
    chk("override_pos",   32'(paddle_pos), 32'(p0 + (ACCEL ? 1 : 8)));

    for (int i = 0; i < 120; i++) step("idle_c", 2'b11, 2'b00, 1'b1, 1'b1);
    chk("retake_owner", 32'(owner), 32'd1);
    for (int i = 0; i < 2; i++) step("ai_dn", 2'b00, 2'b01, 1'b1, 1'b1);
    step("allow_fall", 2'b00, 2'b01, 1'b0, 1'b1);
    chk("allow_fall_owner", 32'(owner), 32'd0);

    for (int i = 0; i < 130; i++) step("sat", 2'b11, 2'b00, 1'b0, 1'b1);
    chk("sat_owner", 32'(owner), 32'd0);
    step("sat_allow", 2'b00, 2'b00, 1'b1, 1'b1);
    chk("sat_allow_owner", 32'(owner), 32'd1);

    for (int i = 0; i < 3; i++) step("pre_rst", 2'b00, 2'b01, 1'b1, 1'b1);
    chk("pre_rst_mov", 32'(moving), 32'd1);
    reset = 1'b1;
    #2;
    chk("mid_rst.pos",    32'(paddle_pos), 32'd200);
    chk("mid_rst.owner",  32'(owner),      32'd0);
    chk("mid_rst.moving", 32'(moving),     32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    step("post_rst", 2'b01, 2'b00, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
